// File: rtl/twmul_seq.sv
// Twiddle-multiply sequencer for one radix-2 DIF stage of the 32-point IFFT.
// Reads the 16 lower-leg samples, feeds the multiplier, and writes the products back in place.
module twmul_seq #(
  parameter int MUL_LAT = 4,
  parameter int DW      = 36
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [2:0]    i_stage,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [4:0]    o_rd_addr,
  output logic          o_rd_en,
  input  logic [DW-1:0] i_rd_dr,
  input  logic [DW-1:0] i_rd_di,
  output logic [DW-1:0] o_mul_dr,
  output logic [DW-1:0] o_mul_di,
  output logic [6:0]    o_mul_twsel,
  input  logic [DW-1:0] i_mul_or,
  input  logic [DW-1:0] i_mul_oi,
  output logic          o_wr_en,
  output logic [4:0]    o_wr_addr,
  output logic [DW-1:0] o_wr_dr,
  output logic [DW-1:0] o_wr_di
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t       r_state;
  logic [2:0]   r_stage;
  logic [3:0]   r_j;
  logic         r_busy;
  logic         r_done;
  logic         r_err;
  logic         r_rd_en;
  logic [4:0]   r_rd_addr;
  logic [6:0]   r_rd_tw;
  logic         r_v1;
  logic [4:0]   r_a1;
  logic [6:0]   r_tw1;
  logic [MUL_LAT-1:0] r_sr_v;
  logic [4:0]   r_sr_a [MUL_LAT];

  logic [2:0]   w_stage;
  logic [3:0]   w_j;
  logic [3:0]   w_mask;
  logic [4:0]   w_span;
  logic [4:0]   w_addr;
  logic [6:0]   w_tw;
  logic         w_empty;

  // In IDLE the address path looks at the incoming stage so j=0 is issued on the accept edge.
  always_comb begin
    w_stage = (r_state == S_IDLE) ? i_stage : r_stage;
    w_j     = (r_state == S_IDLE) ? 4'd0 : r_j;
    w_span  = 5'd16 >> w_stage;
    w_mask  = w_span[3:0] - 4'd1;
    w_addr  = {(w_j & ~w_mask), 1'b0} + {1'b0, (w_j & w_mask)} + w_span;
    w_tw    = {w_stage, 4'b0000} + {3'b000, w_j} + 7'd1;
    w_empty = !r_rd_en && !r_v1 && (r_sr_v[MUL_LAT-2:0] == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_stage   <= '0;
      r_j       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_rd_tw   <= '0;
      r_v1      <= 1'b0;
      r_a1      <= '0;
      r_tw1     <= '0;
      r_sr_v    <= '0;
      for (int k = 0; k < MUL_LAT; k++) r_sr_a[k] <= '0;
    end else begin
      r_err  <= 1'b0;
      r_done <= 1'b0;
      r_v1   <= r_rd_en;
      r_a1   <= r_rd_en ? r_rd_addr : 5'd0;
      r_tw1  <= r_rd_en ? r_rd_tw : 7'd0;
      r_sr_v <= {r_sr_v[MUL_LAT-2:0], r_v1};
      r_sr_a[0] <= r_v1 ? r_a1 : 5'd0;
      for (int k = 1; k < MUL_LAT; k++) r_sr_a[k] <= r_sr_a[k-1];
      case (r_state)
        S_IDLE: begin
          r_rd_en   <= 1'b0;
          r_rd_addr <= '0;
          r_rd_tw   <= '0;
          r_busy    <= 1'b0;
          if (i_start) begin
            if (i_stage <= 3'd4) begin
              r_stage   <= i_stage;
              r_j       <= 4'd1;
              r_rd_en   <= 1'b1;
              r_rd_addr <= w_addr;
              r_rd_tw   <= w_tw;
              r_busy    <= 1'b1;
              r_state   <= S_ISSUE;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_rd_en   <= 1'b1;
          r_rd_addr <= w_addr;
          r_rd_tw   <= w_tw;
          r_j       <= r_j + 4'd1;
          if (r_j == 4'd15) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_rd_en   <= 1'b0;
          r_rd_addr <= '0;
          r_rd_tw   <= '0;
          if (r_done) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_empty) begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_rd_en     = r_rd_en;
  assign o_rd_addr   = r_rd_addr;
  assign o_mul_dr    = r_v1 ? i_rd_dr : '0;
  assign o_mul_di    = r_v1 ? i_rd_di : '0;
  assign o_mul_twsel = r_tw1;
  assign o_wr_en     = r_sr_v[MUL_LAT-1];
  assign o_wr_addr   = r_sr_a[MUL_LAT-1];
  assign o_wr_dr     = o_wr_en ? i_mul_or : '0;
  assign o_wr_di     = o_wr_en ? i_mul_oi : '0;

endmodule

// File: tb/tb_twmul_seq.sv
// Scoreboard bench for twmul_seq: behavioural buffer and multiplier, expectations queued at start.
module tb_twmul_seq;
  localparam int DW  = 36;
  localparam int LAT = 4;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0]    stage = '0;
  logic          busy, done, err, rd_en, wr_en;
  logic [4:0]    rd_addr, wr_addr;
  logic [DW-1:0] rd_dr, rd_di, mul_dr, mul_di, mul_or, mul_oi, wr_dr, wr_di;
  logic [6:0]    mul_twsel;

  twmul_seq #(.MUL_LAT(LAT), .DW(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stage(stage),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_rd_addr(rd_addr), .o_rd_en(rd_en), .i_rd_dr(rd_dr), .i_rd_di(rd_di),
    .o_mul_dr(mul_dr), .o_mul_di(mul_di), .o_mul_twsel(mul_twsel),
    .i_mul_or(mul_or), .i_mul_oi(mul_oi),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_dr(wr_dr), .o_wr_di(wr_di));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // twiddle index >= 65 is W = 1; other indices get a distinct, checkable transform
  function automatic logic [DW-1:0] tw_re(logic [DW-1:0] x, int t);
    return (t >= 65) ? x : x + DW'(t * 1000);
  endfunction
  function automatic logic [DW-1:0] tw_im(logic [DW-1:0] x, int t);
    return (t >= 65) ? x : x ^ DW'(t);
  endfunction

  logic [DW-1:0] mem_r [32], mem_i [32];
  logic [DW-1:0] p_r [LAT], p_i [LAT];
  logic [6:0]    p_t [LAT];

  initial begin
    rd_dr = '0; rd_di = '0;
    for (int k = 0; k < LAT; k++) begin p_r[k] = '0; p_i[k] = '0; p_t[k] = '0; end
    for (int a = 0; a < 32; a++) begin
      mem_r[a] = {DW'($urandom)} ^ (DW'($urandom_range(0, 15)) << 32);
      mem_i[a] = {DW'($urandom)} ^ (DW'(a) << 30);
    end
  end

  always @(posedge clk) begin
    if (rd_en) begin rd_dr <= mem_r[rd_addr]; rd_di <= mem_i[rd_addr]; end
    if (wr_en) begin mem_r[wr_addr] <= wr_dr; mem_i[wr_addr] <= wr_di; end
    p_r[0] <= mul_dr; p_i[0] <= mul_di; p_t[0] <= mul_twsel;
    for (int k = 1; k < LAT; k++) begin p_r[k] <= p_r[k-1]; p_i[k] <= p_i[k-1]; p_t[k] <= p_t[k-1]; end
  end
  assign mul_or = tw_re(p_r[LAT-1], int'(p_t[LAT-1]));
  assign mul_oi = tw_im(p_i[LAT-1], int'(p_t[LAT-1]));

  typedef struct { int a; logic [DW-1:0] r; logic [DW-1:0] i; } item_t;
  int    q_rd[$];
  item_t q_mi[$];
  item_t q_wr[$];

  int t0 = 0, wr_first = -1, wr_last = -1, wr_cnt = 0, done_cyc = -1, done_total = 0;

  task automatic chk(string nm, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc - t0);
    end
  endtask

  always @(negedge clk) begin
    item_t it;
    if (rd_en) begin
      if (q_rd.size() == 0) chk("rd_extra", 1, 0);
      else chk("rd_addr", rd_addr, q_rd.pop_front());
    end
    if (mul_twsel != 0) begin
      if (q_mi.size() == 0) chk("mul_extra", 1, 0);
      else begin
        it = q_mi.pop_front();
        chk("mul_twsel", mul_twsel, it.a);
        chk("mul_dr", mul_dr, it.r);
        chk("mul_di", mul_di, it.i);
      end
    end
    if (wr_en) begin
      if (q_wr.size() == 0) chk("wr_extra", 1, 0);
      else begin
        it = q_wr.pop_front();
        chk("wr_addr", wr_addr, it.a);
        chk("wr_dr", wr_dr, it.r);
        chk("wr_di", wr_di, it.i);
      end
      if (wr_first < 0) wr_first = cyc;
      wr_last = cyc;
      wr_cnt++;
    end
    if (done) begin done_cyc = cyc; done_total++; end
  end

  // Reference: address and twiddle from the stage arithmetic, data from the buffer image.
  task automatic push_model(int s);
    int span, a, t;
    item_t it;
    span = 16 >> s;
    for (int j = 0; j < 16; j++) begin
      a = (j / span) * 2 * span + (j % span) + span;
      t = 16 * s + j + 1;
      q_rd.push_back(a);
      it.a = t; it.r = mem_r[a]; it.i = mem_i[a];
      q_mi.push_back(it);
      it.a = a; it.r = tw_re(mem_r[a], t); it.i = tw_im(mem_i[a], t);
      q_wr.push_back(it);
    end
  endtask

  task automatic issue(int s);
    start = 1'b1; stage = 3'(s);
    t0 = cyc; wr_first = -1; wr_last = -1; wr_cnt = 0; done_cyc = -1;
    if (s <= 4) push_model(s);
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60; k++) begin
      if (done_cyc >= 0) break;
      @(negedge clk); #1;
    end
    chk("done_cycle", done_cyc - t0, 18 + LAT);
    chk("busy_at_done", busy, 1);
    chk("wr_first", wr_first - t0, 2 + LAT);
    chk("wr_last", wr_last - t0, 17 + LAT);
    chk("wr_count", wr_cnt, 16);
    chk("queue_left", q_rd.size() + q_mi.size() + q_wr.size(), 0);
  endtask

  task automatic run(int s);
    issue(s);
    chk("busy_start", busy, 1);
    chk("rd_en_start", rd_en, 1);
    wait_done();
    @(negedge clk); #1;
    chk("busy_end", busy, 0);
  endtask

  int dtot;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_twsel", mul_twsel, 0);
    rst = 1'b0;
    @(negedge clk); #1;

    run(0);
    run(2);
    run(4);
    for (int r = 0; r < 2; r++) run(int'($urandom_range(0, 4)));

    // start during a busy stage-1 run is ignored
    issue(1);
    repeat (4) @(negedge clk);
    #1;
    start = 1'b1; stage = 3'd3;
    @(negedge clk); #1;
    start = 1'b0;
    chk("busy_start_err", err, 0);
    wait_done();
    @(negedge clk); #1;

    // out-of-range stage
    issue(5);
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    @(negedge clk); #1;
    chk("err_clear", err, 0);
    repeat (5) @(negedge clk);
    #1;

    // reset in cycle 10 of a stage-1 run
    issue(1);
    repeat (9) @(negedge clk);
    #1;
    rst = 1'b1;
    q_rd.delete(); q_mi.delete(); q_wr.delete();
    dtot = done_total;
    @(negedge clk); #1;
    chk("rst_mid_wr_en", wr_en, 0);
    chk("rst_mid_busy", busy, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("rst_mid_no_done", done_total, dtot);
    run(1);

    // back-to-back: start in the done cycle is ignored, one cycle later accepted
    issue(2);
    wait_done();
    start = 1'b1; stage = 3'd3;
    @(negedge clk); #1;
    chk("b2b_ignored", busy, 0);
    issue(3);
    chk("b2b_busy", busy, 1);
    wait_done();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/twmul_seq.md
# twmul_seq

Sequencer that drives the twiddle multiplier for one radix-2 DIF stage of the 32-point IFFT. On `start` it reads the 16 lower-leg butterfly samples of the selected stage from the sample buffer. It presents each sample to the multiplier with the matching twiddle select, realigns the products returned after the multiplier's fixed latency, and writes them back in place. It sits between the stage controller (start/done) and the sample buffer / twiddle multiplier pair.

## Interface
- `MUL_LAT`, 4, multiplier latency in clocks from input to `mul_or`/`mul_oi`.
- `DW`, 36, sample component width (two's complement).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset rst, synchronous, active-high.
- `start`  in  1  one-cycle request, sampled only in IDLE.
- `stage`  in  3  stage number 0..4, sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse after the last write-back.
- `err`  out  1  one-cycle pulse when `start` arrives with `stage` > 4.
- `rd_addr`  out  5  buffer read address.
- `rd_en`  out  1  buffer read strobe.
- `rd_dr`, `rd_di`  in  DW  buffer read data; valid the cycle after `rd_en`.
- `mul_dr`, `mul_di`  out  DW  multiplier data inputs.
- `mul_twsel`  out  7  multiplier twiddle select.
- `mul_or`, `mul_oi`  in  DW  multiplier product.
- `wr_en`  out  1  write-back strobe.
- `wr_addr`  out  5  write-back address.
- `wr_dr`, `wr_di`  out  DW  write-back data.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - `start` with `stage` ≤ 4 latches `stage`, clears index j, and moves to ISSUE.
  - `start` with `stage` > 4 pulses `err` next cycle and stays in IDLE.
- ISSUE: one read per cycle for j = 0..15, then moves to DRAIN after j = 15.
- Address per j:
  - span = 16 >> stage; grp = j / span; off = j mod span.
  - addr = grp·2·span + off + span.
- Twiddle select: `mul_twsel` = 16·stage + j + 1 (range 1..80).
- Datapath:
  - Read data goes to `mul_dr`/`mul_di` unmodified, registered one cycle after `rd_en`.
  - `mul_twsel` is registered so that it is aligned with the data.
  - When no valid item is presented, `mul_dr`, `mul_di` and `mul_twsel` are driven to 0.
- Realignment:
  - A shift register of depth MUL_LAT carries {valid, addr} in parallel with the multiplier.
  - Its output drives `wr_en`/`wr_addr`.
  - `wr_dr`/`wr_di` = `mul_or`/`mul_oi`, passed through combinationally in the `wr_en` cycle.
- DRAIN: waits until the shift register is empty, pulses `done`, and returns to IDLE.
- `start` while `busy` is ignored: no `err`, no restart.
- No stall input: the buffer and the multiplier are always ready.

## Timing
- Reset values: all outputs 0, state IDLE, shift register cleared.
- `rst` mid-operation: the next cycle is IDLE and no further `wr_en` or `done` is produced. A partially written stage is left as is.
- Start accepted on the edge at cycle 0:
  - `rd_en` high in cycles 1..16.
  - Multiplier inputs valid in cycles 2..17.
  - `wr_en` high in cycles 2+MUL_LAT..17+MUL_LAT (6..21 for the default).
  - `done` in cycle 18+MUL_LAT (22).
  - `busy` is high in cycles 1..22.
- Throughput: exactly 16 consecutive writes, with no gaps.
- A new `start` is accepted in the cycle after `done`, giving a back-to-back period of MUL_LAT+19 cycles.
- Write addresses are the same sequence as the read addresses, delayed by 1+MUL_LAT cycles.

## Test plan
- Stage 0, with the buffer holding addr·1 + j·(2^20): start at cycle 0.
  - Reads at addresses 16..31.
  - `mul_twsel` 1..16.
  - `wr_addr` 16..31 in cycles 6..21.
  - `done` at cycle 22.
- Stage 2:
  - j = 5 reads and writes address 13 with `mul_twsel` 38.
  - Full read address order: 4,5,6,7,12,13,14,15,20,21,22,23,28,29,30,31.
- Stage 4:
  - Read addresses 1,3,...,31.
  - `mul_twsel` 65..80.
  - With the real multiplier, each written value equals the value read, because W = 1.
- `start` with `stage` = 5: `err` pulses one cycle later, `busy` stays 0, and there are no reads or writes. `start` again during stage 1 busy: ignored.
- `rst` asserted at cycle 10 of a stage-1 run:
  - `wr_en` is 0 from cycle 11 on and `done` never fires.
  - A subsequent `start` runs the full sequence normally.
- Back-to-back: a stage 3 start in the same cycle as stage 2 `done` is ignored; the same start one cycle later is accepted and completes in 22 cycles.
